// File: rtl/calc_display.sv
// calc_display: receiving end of the calculator digit-print interface.
// A print frame is collected digit by digit into a shadow buffer. When the
// frame ends it is copied to the display buffer, which is then scanned
// across eight common-anode 7-segment digits. The block also shows an
// "Erro" pattern and lights every decimal point while the calculator is busy.
//
// Handshake: there is no backpressure. data/pos are valid in any cycle
// where status==2'b11; every such cycle with pos in 1..8 is one digit
// write. A cycle with status==2'b10 after a capture ends the frame.
module calc_display #(
  parameter int REFRESH_DIV   = 1000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;
  localparam logic [1:0] ST_ERROR   = 2'd3;

  localparam logic [1:0] STAT_ERROR = 2'b00;
  localparam logic [1:0] STAT_BUSY  = 2'b01;
  localparam logic [1:0] STAT_READY = 2'b10;
  localparam logic [1:0] STAT_PRINT = 2'b11;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_O     = 7'b0100011;

  // BCD to active-low {g,f,e,d,c,b,a}; codes 10..15 show nothing.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   display_q, display_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    scan_q, scan_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;

  // Digit slot decode: pos 1..8 maps to nibble 0..7, anything else is dropped.
  logic       pos_ok;
  logic [3:0] pos_m1;
  logic [2:0] slot;
  assign pos_ok = (pos >= 4'd1) && (pos <= 4'd8);
  assign pos_m1 = pos - 4'd1;
  assign slot   = pos_m1[2:0];

  // Same-cycle digit merged into the running shadow, or into a fresh frame.
  logic [31:0] shadow_wr;
  logic [31:0] fresh_wr;
  always_comb begin
    shadow_wr = shadow_q;
    fresh_wr  = '0;
    if (pos_ok) begin
      shadow_wr[{slot, 2'b00} +: 4] = data;
      fresh_wr[{slot, 2'b00} +: 4]  = data;
    end
  end

  // Frame FSM: capture into shadow, commit into display, latch errors.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    display_d = display_q;
    case (state_q)
      ST_IDLE: begin
        if (status == STAT_PRINT) begin
          state_d  = ST_CAPTURE;
          shadow_d = fresh_wr;
        end else if (status == STAT_ERROR) begin
          state_d = ST_ERROR;
        end
      end
      ST_CAPTURE: begin
        case (status)
          STAT_PRINT: shadow_d = shadow_wr;
          STAT_READY: state_d = ST_COMMIT;
          STAT_ERROR: begin
            state_d  = ST_ERROR;
            shadow_d = '0;
          end
          default: begin
            state_d  = ST_IDLE;
            shadow_d = '0;
          end
        endcase
      end
      ST_COMMIT: begin
        display_d = shadow_q;
        if (status == STAT_PRINT) begin
          state_d  = ST_CAPTURE;
          shadow_d = fresh_wr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // frame_done is high for exactly the cycle the FSM spends in COMMIT.
  always_comb begin
    frame_done_d = (state_d == ST_COMMIT);
  end

  // Refresh timer and scan index.
  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    scan_d = scan_q;
    if (cnt_q == CW'(REFRESH_DIV - 1)) begin
      cnt_d  = '0;
      scan_d = scan_q + 3'd1;
    end
  end

  // Segment pattern for the digit currently selected.
  logic [3:0]  cur_digit;
  logic [31:0] upper_digits;
  logic        lead_blank;
  assign cur_digit    = display_q[{scan_q, 2'b00} +: 4];
  assign upper_digits = display_q >> {scan_q, 2'b00};
  assign lead_blank   = BLANK_LEADING && (scan_q != 3'd0) && (upper_digits == 32'd0);

  // Anode, segments and dp all come from the same scan index so they switch together.
  always_comb begin
    an_d = ~(8'b0000_0001 << scan_q);
    dp_d = !((state_q == ST_IDLE) && (status == STAT_BUSY));
    if (state_q == ST_ERROR) begin
      case (scan_q)
        3'd3:    seg_d = SEG_E;
        3'd2:    seg_d = SEG_R;
        3'd1:    seg_d = SEG_R;
        3'd0:    seg_d = SEG_O;
        default: seg_d = SEG_BLANK;
      endcase
    end else if (lead_blank) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg_decode(cur_digit);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      shadow_q     <= '0;
      display_q    <= '0;
      cnt_q        <= '0;
      scan_q       <= '0;
      an_q         <= 8'hFF;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      cnt_q        <= cnt_d;
      scan_q       <= scan_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_calc_display.sv
// Bench for calc_display: two instances share the inputs, one with leading
// zero blanking and one without, so both display policies are checked on
// every scanned digit.
module tb_calc_display;

  localparam int RD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] status = 2'b10;
  logic [3:0] data = 4'd0;
  logic [3:0] pos = 4'd0;

  logic [7:0] an1, an0;
  logic [6:0] seg1, seg0;
  logic       dp1, dp0, fd1, fd0;

  int checks = 0;
  int errors = 0;
  int fd1_cnt = 0;
  int fd0_cnt = 0;

  // {an, seg(blanking), seg(no blanking), dp}
  logic [22:0] exp_q[$];

  // Clock
  always #5 clock = ~clock;

  calc_display #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b1)) dut (
    .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
    .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1)
  );

  calc_display #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b0)) dut0 (
    .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
    .an(an0), .seg(seg0), .dp(dp0), .frame_done(fd0)
  );

  // Count cycles in which frame_done is high.
  always @(negedge clock) begin
    if (fd1 === 1'b1) fd1_cnt++;
    if (fd0 === 1'b1) fd0_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected scan word for digit k of frame f.
  function automatic logic [22:0] exp_word(input int k, input logic [31:0] f,
                                           input bit err, input bit dpv);
    logic [7:0] a;
    logic [6:0] s1, s0;
    int lead;
    a = ~(8'b1 << k);
    if (err) begin
      case (k)
        3: s0 = 7'b0000110;
        2: s0 = 7'b0101111;
        1: s0 = 7'b0101111;
        0: s0 = 7'b0100011;
        default: s0 = 7'b1111111;
      endcase
      s1 = s0;
    end else begin
      lead = 0;
      for (int j = 0; j < 8; j++) if (f[4*j +: 4] != 4'd0) lead = j;
      s0 = dec(f[4*k +: 4]);
      s1 = (k > lead) ? 7'b1111111 : s0;
    end
    return {a, s1, s0, dpv};
  endfunction

  task automatic push_scan(input logic [31:0] f, input bit err, input bit dpv);
    for (int k = 0; k < 8; k++) exp_q.push_back(exp_word(k, f, err, dpv));
  endtask

  // Pop one expected word each time its anode comes up in the scan.
  task automatic drain(input string tag);
    int budget;
    logic [22:0] head;
    logic [22:0] got;
    budget = 24 * RD;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clock);
      budget--;
      head = exp_q[0];
      if (an1 === head[22:15]) begin
        got = {an1, seg1, seg0, dp1};
        void'(exp_q.pop_front());
        check(tag, {9'd0, got}, {9'd0, head});
      end
    end
    check({tag, "_timeout"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic send_frame(input logic [31:0] f);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      status = 2'b11;
      pos    = 4'(i + 1);
      data   = f[4*i +: 4];
    end
    @(negedge clock);
    status = 2'b10;
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clock);
    reset = 1'b0;
    repeat (n) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int n1, n0;

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_an", {24'd0, an1}, 32'hFF);
    check("rst_seg", {25'd0, seg1}, 32'h7F);
    check("rst_dp", {31'd0, dp1}, 32'd1);
    check("rst_fd", {31'd0, fd1}, 32'd0);
    check("rst_an0", {24'd0, an0}, 32'hFF);
    check("rst_seg0", {25'd0, seg0}, 32'h7F);
    reset = 1'b1;
    @(negedge clock);
    check("first_an", {24'd0, an1}, 32'hFE);
    check("first_seg", {25'd0, seg1}, 32'h40);

    // Idle scan of an all-zero display
    push_scan(32'h0, 1'b0, 1'b1);
    drain("idle");

    // Print 12345
    n1 = fd1_cnt; n0 = fd0_cnt;
    send_frame(32'h0001_2345);
    repeat (4) @(negedge clock);
    check("fd_12345", fd1_cnt, n1 + 1);
    check("fd0_12345", fd0_cnt, n0 + 1);
    push_scan(32'h0001_2345, 1'b0, 1'b1);
    drain("f12345");

    // Repeated slot, out-of-range pos, non-BCD data
    n1 = fd1_cnt;
    @(negedge clock); status = 2'b11; pos = 4'd1;  data = 4'd1;
    @(negedge clock); pos = 4'd3;  data = 4'd4;
    @(negedge clock); pos = 4'd3;  data = 4'd6;
    @(negedge clock); pos = 4'd0;  data = 4'd9;
    @(negedge clock); pos = 4'd12; data = 4'd8;
    @(negedge clock); pos = 4'd2;  data = 4'd12;
    @(negedge clock); status = 2'b10;
    repeat (4) @(negedge clock);
    check("fd_misc", fd1_cnt, n1 + 1);
    push_scan(32'h0000_06C1, 1'b0, 1'b1);
    drain("misc");

    // Frame 99, then an aborted partial frame while busy
    send_frame(32'h0000_0099);
    repeat (4) @(negedge clock);
    push_scan(32'h0000_0099, 1'b0, 1'b1);
    drain("f99");
    n1 = fd1_cnt;
    @(negedge clock); status = 2'b11; pos = 4'd1; data = 4'd7;
    @(negedge clock); status = 2'b01;
    repeat (3) @(negedge clock);
    push_scan(32'h0000_0099, 1'b0, 1'b0);
    drain("busy");
    check("fd_abort", fd1_cnt, n1);
    status = 2'b10;
    repeat (3) @(negedge clock);

    // Error mid-capture, later frames ignored
    @(negedge clock); status = 2'b11; pos = 4'd1; data = 4'd3;
    @(negedge clock); status = 2'b00;
    @(negedge clock); status = 2'b10;
    repeat (3) @(negedge clock);
    push_scan(32'h0, 1'b1, 1'b1);
    drain("err");
    n1 = fd1_cnt;
    send_frame(32'h8888_8888);
    repeat (4) @(negedge clock);
    check("fd_err", fd1_cnt, n1);
    push_scan(32'h0, 1'b1, 1'b1);
    drain("err_hold");

    // Reset out of error, then a one-cycle reset mid-frame
    pulse_reset(2);
    repeat (2) @(negedge clock);
    @(negedge clock); status = 2'b11; pos = 4'd1; data = 4'd5;
    @(negedge clock); pos = 4'd2; data = 4'd6;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("mid_rst_an", {24'd0, an1}, 32'hFF);
    check("mid_rst_seg", {25'd0, seg1}, 32'h7F);
    n1 = fd1_cnt;
    send_frame(32'h8765_4321);
    repeat (4) @(negedge clock);
    check("fd_after_rst", fd1_cnt, n1 + 1);
    push_scan(32'h8765_4321, 1'b0, 1'b1);
    drain("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
